// File: rtl/out_piso_ctrl.sv
// out_piso_ctrl: captures LANES-wide activated batches and drains them lane 0 first on a DW-bit valid/ready stream.
// Latency: a load into an empty shift register is visible on dout/dout_valid right after the capturing edge; 1 element/cycle.
// Backpressure: dout/idx hold while dout_ready is low; one pending batch is buffered, a further load is dropped and flagged.
module out_piso_ctrl #(
  parameter int LANES = 4,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clr,
  input  logic                load,
  input  logic                last,
  input  logic [LANES*DW-1:0] din,
  output logic [DW-1:0]       dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                out_done,
  output logic                busy,
  output logic                overrun
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  logic [LANES*DW-1:0] sr_q, sr_d, pb_q, pb_d;
  logic                sr_v_q, sr_v_d, sr_last_q, sr_last_d;
  logic                pb_v_q, pb_v_d, pb_last_q, pb_last_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                xfer;
  logic                load_pending;

  assign xfer       = sr_v_q & dout_ready;
  assign dout       = sr_q[idx_q*DW +: DW];
  assign dout_valid = sr_v_q;
  assign busy       = sr_v_q | pb_v_q;
  assign out_done   = done_q;
  assign overrun    = ovr_q;

  // Next-state: clear, then serial transfer / batch refill, then placement of any load not already consumed.
  always_comb begin
    sr_d         = sr_q;
    sr_v_d       = sr_v_q;
    sr_last_d    = sr_last_q;
    pb_d         = pb_q;
    pb_v_d       = pb_v_q;
    pb_last_d    = pb_last_q;
    idx_d        = idx_q;
    done_d       = done_q;
    ovr_d        = ovr_q;
    load_pending = 1'b0;
    if (enable) begin
      if (clr) begin
        // Data registers keep their contents; only the occupancy/status bits are cleared.
        sr_v_d = 1'b0;
        pb_v_d = 1'b0;
        idx_d  = '0;
        done_d = 1'b0;
        ovr_d  = 1'b0;
      end else begin
        load_pending = load;
        if (xfer) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = '0;
            if (sr_last_q) done_d = 1'b1;
            if (pb_v_q) begin
              sr_d      = pb_q;
              sr_last_d = pb_last_q;
              pb_v_d    = 1'b0;
            end else if (load) begin
              // Refill straight from din so back-to-back batches have no bubble.
              sr_d         = din;
              sr_last_d    = last;
              load_pending = 1'b0;
            end else begin
              sr_v_d = 1'b0;
            end
          end
        end
        if (load_pending) begin
          if (!sr_v_q) begin
            sr_d      = din;
            sr_v_d    = 1'b1;
            sr_last_d = last;
          end else if (!pb_v_d) begin
            // pb_v_d is low when pb was empty or is being moved into sr this cycle.
            pb_d      = din;
            pb_v_d    = 1'b1;
            pb_last_d = last;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
    end
  end

  // State registers; asynchronous reset zeros everything so all outputs read 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q      <= '0;
      sr_v_q    <= 1'b0;
      sr_last_q <= 1'b0;
      pb_q      <= '0;
      pb_v_q    <= 1'b0;
      pb_last_q <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      sr_v_q    <= sr_v_d;
      sr_last_q <= sr_last_d;
      pb_q      <= pb_d;
      pb_v_q    <= pb_v_d;
      pb_last_q <= pb_last_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

endmodule

// File: tb/tb_out_piso_ctrl.sv
// tb_out_piso_ctrl: directed scenarios plus random traffic against a queue-of-batches reference model.
// Outputs sampled on the falling edge; inputs driven on the falling edge for the next rising edge.
// The model treats storage as a FIFO of at most two batches with a lane cursor on the head batch.
module tb_out_piso_ctrl;
  localparam int LANES = 4;
  localparam int DW    = 8;

  logic                clk;
  logic                reset;
  logic                enable;
  logic                clr;
  logic                load;
  logic                last;
  logic [LANES*DW-1:0] din;
  logic [DW-1:0]       dout;
  logic                dout_valid;
  logic                dout_ready;
  logic                out_done;
  logic                busy;
  logic                overrun;

  out_piso_ctrl #(.LANES(LANES), .DW(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clr(clr), .load(load), .last(last),
    .din(din), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .out_done(out_done), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*DW-1:0] data;
    bit                  lst;
  } batch_t;

  batch_t     m_q[$];
  int         m_pos;
  bit         m_done;
  bit         m_ovr;
  logic [7:0] xlog[$];
  int         n_chk;
  int         n_fail;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] packlog();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < xlog.size() && i < 8; i++) v[i*8 +: 8] = xlog[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] lane_of(input logic [LANES*DW-1:0] d, input int p);
    logic [LANES*DW-1:0] s;
    s = d >> (p * DW);
    return s[DW-1:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pos  = 0;
    m_done = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // One clock: compare against the model, drive inputs, advance the model, then move to the next falling edge.
  task automatic step(input bit en, input bit cl, input bit ld, input bit lst,
                      input logic [LANES*DW-1:0] d, input bit rdy);
    batch_t b;
    chk("dout_valid", dout_valid, m_q.size() > 0);
    chk("busy", busy, m_q.size() > 0);
    chk("out_done", out_done, m_done);
    chk("overrun", overrun, m_ovr);
    if (m_q.size() > 0) chk("dout", dout, lane_of(m_q[0].data, m_pos));
    enable     = en;
    clr        = cl;
    load       = ld;
    last       = lst;
    din        = d;
    dout_ready = rdy;
    if (en) begin
      if (cl) begin
        m_q.delete();
        m_pos  = 0;
        m_done = 1'b0;
        m_ovr  = 1'b0;
      end else begin
        if (m_q.size() > 0 && rdy) begin
          xlog.push_back(lane_of(m_q[0].data, m_pos));
          m_pos++;
          if (m_pos == LANES) begin
            m_pos = 0;
            if (m_q[0].lst) m_done = 1'b1;
            void'(m_q.pop_front());
          end
        end
        if (ld) begin
          if (m_q.size() < 2) begin
            b.data = d;
            b.lst  = lst;
            m_q.push_back(b);
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, rdy);
  endtask

  task automatic do_clr();
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    reset      = 1'b0;
    enable     = 1'b0;
    clr        = 1'b0;
    load       = 1'b0;
    last       = 1'b0;
    din        = '0;
    dout_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset dout", dout, 8'h00);
    chk("reset dout_valid", dout_valid, 1'b0);
    chk("reset out_done", out_done, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // 1: basic drain with ready held high.
    xlog.delete();
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h44332211, 1'b1);
    chk("t1 lane0 after load", dout, 8'h11);
    repeat (4) idle(1'b1);
    chk("t1 count", xlog.size(), 4);
    chk("t1 seq", packlog(), 64'h44332211);
    chk("t1 out_done", out_done, 1'b1);
    chk("t1 busy", busy, 1'b0);
    do_clr();

    // 2: backpressure pattern 1,0,0,1,1,0,1.
    xlog.delete();
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h44332211, 1'b0);
    idle(1'b1); idle(1'b0); idle(1'b0);
    chk("t2 held lane1", dout, 8'h22);
    idle(1'b1); idle(1'b1); idle(1'b0); idle(1'b1);
    chk("t2 count", xlog.size(), 4);
    chk("t2 seq", packlog(), 64'h44332211);
    do_clr();

    // 3: pending buffer, no bubble between batches.
    xlog.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h04030201, 1'b1);
    idle(1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h08070605, 1'b1);
    repeat (5) idle(1'b1);
    chk("t3 no done before 08", out_done, 1'b0);
    idle(1'b1);
    chk("t3 count", xlog.size(), 8);
    chk("t3 seq", packlog(), 64'h0807060504030201);
    chk("t3 out_done", out_done, 1'b1);
    do_clr();

    // 4: overrun with ready low, then drain A and B only.
    xlog.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h04030201, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h08070605, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0c0b0a09, 1'b0);
    chk("t4 overrun", overrun, 1'b1);
    repeat (10) idle(1'b1);
    chk("t4 count", xlog.size(), 8);
    chk("t4 seq", packlog(), 64'h0807060504030201);
    chk("t4 done", out_done, 1'b1);
    do_clr();
    chk("t4 clr overrun", overrun, 1'b0);
    chk("t4 clr busy", busy, 1'b0);
    chk("t4 clr out_done", out_done, 1'b0);

    // 5: enable low for 3 cycles mid-batch (load and ready asserted but ignored).
    xlog.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'hddccbbaa, 1'b1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h99999999, 1'b1);
      chk("t5 frozen dout", dout, 8'hbb);
      chk("t5 frozen valid", dout_valid, 1'b1);
    end
    repeat (4) idle(1'b1);
    chk("t5 count", xlog.size(), 4);
    chk("t5 seq", packlog(), 64'hddccbbaa);
    chk("t5 busy", busy, 1'b0);
    do_clr();

    // 6: asynchronous reset after lane 1 has gone out.
    xlog.delete();
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h44332211, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t6 mid-batch lane2", dout, 8'h33);
    #2 reset = 1'b0;
    #1;
    chk("t6 rst dout", dout, 8'h00);
    chk("t6 rst valid", dout_valid, 1'b0);
    chk("t6 rst busy", busy, 1'b0);
    chk("t6 rst done", out_done, 1'b0);
    chk("t6 rst overrun", overrun, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) idle(1'b1);
    chk("t6 no drain after release", dout_valid, 1'b0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 4) < 3);
    end
    repeat (20) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/out_piso_ctrl.md
# out_piso_ctrl

Output-side counterpart of the accumulate/ReLU control FSM in the NPU datapath. Each time the accumulate FSM pulses its ReLU enable, this block captures one parallel batch of `LANES` activated neuron results. It drains the batch one element per handshake onto a narrow valid/ready stream. It raises `out_done` once the batch flagged as last has fully drained, which releases the accumulate FSM from its WAIT state. A one-batch pending buffer lets the accumulate FSM load the next batch while the current one is still shifting out.

## Interface
- `LANES`, default 4: elements per parallel batch (≥2).
- `DW`, default 8: element width in bits.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global clock-enable; when low, all state is frozen.
- `clr`  in  1  synchronous clear (driven by CLR_PISO_OUT).
- `load`  in  1  capture `din` (driven by EN_ReLU).
- `last`  in  1  sampled with `load`; marks the batch as the final one.
- `din`  in  LANES*DW  parallel batch; lane 0 = `din[DW-1:0]`.
- `dout`  out  DW  current serial element.
- `dout_valid`  out  1  `dout` holds a valid element.
- `dout_ready`  in  1  downstream accepts the element.
- `out_done`  out  1  final batch fully drained (level signal).
- `busy`  out  1  shift register or pending buffer occupied.
- `overrun`  out  1  sticky flag: a load was dropped.

## Operation
- **Storage:**
  - shift register `sr` with `sr_v`, `sr_last` and lane counter `idx` (0..LANES-1);
  - pending buffer `pb` with `pb_v`, `pb_last`.
- **States:**
  - EMPTY (`sr_v`=0, `done`=0);
  - SHIFT (`sr_v`=1);
  - DONE (`out_done`=1).
- **Outputs:**
  - `dout` = `sr` lane `idx`; `dout_valid` = `sr_v`;
  - `busy` = `sr_v` | `pb_v`.
- **Transfer:** occurs when `enable` & `dout_valid` & `dout_ready`.
  - Non-final lane (`idx`<LANES-1): `idx`++.
  - Final lane (`idx`=LANES-1): `idx`←0, then
    - if `pb_v`: `sr`←`pb`, `pb_v`←0;
    - else if `load` in the same cycle: `sr`←`din` (no bubble);
    - else `sr_v`←0.
  - If the completed batch had `sr_last`=1: go to DONE, set `out_done`=1.
- **Load** (when `enable` & `load`, not consumed by the final-lane rule above):
  - `sr` empty or being vacated → `sr`;
  - else `pb` empty or being vacated → `pb`;
  - else data is dropped and `overrun`←1.
- **DONE state:**
  - `out_done` holds high until `clr`.
  - Loads in DONE are accepted normally. They do not clear `out_done`.
- **`clr`:**
  - Requires `enable`.
  - Has priority over `load` and transfer.
  - Clears `sr_v`, `pb_v`, `idx`, `out_done` and `overrun`. Data registers keep their value.
- **`enable`=0:** nothing changes. `dout`/`dout_valid` stay stable, so the handshake is also paused.
- **Lane order:** lane 0 is sent first. Values pass through unchanged (no width conversion).

## Timing
- **Reset:** all registers are 0, so every output is 0 (`dout`=0, `dout_valid`=0, `out_done`=0, `busy`=0, `overrun`=0).
- **Load latency:** `load` at edge t into empty `sr` → `dout_valid`=1 with lane 0 after edge t.
- **Throughput:** one element per cycle with `dout_ready`=1. Back-to-back batches have no idle cycle.
- **`out_done` latency:** high after the edge of the final lane's transfer in the `last` batch.
- **Handshake:** while `dout_valid`=1 and `dout_ready`=0, `dout` and `idx` hold. `dout_valid` never drops without a transfer, except on `clr` or reset.
- **Reset mid-batch:** an asynchronous assertion immediately zeros all outputs. There is no partial drain after release.
- **Simultaneous events:**
  - `clr` + `load`: clear wins and the load is lost (no overrun flag).
  - final transfer + `load` with `pb` full: `pb`→`sr` and `din`→`pb`, with no overrun.

## Test plan
1. **Basic drain.** LANES=4, DW=8, `ready`=1.
   - Stimulus: load `din`=0x44332211, `last`=1.
   - Required: `dout` = 11,22,33,44 on consecutive cycles. `out_done`=1 after the 4th transfer; `busy`=0.
2. **Backpressure.**
   - Stimulus: same load; toggle `ready` 1,0,0,1,1,0,1.
   - Required: each element is held during the stalls. Sequence 11,22,33,44 is unchanged, with no duplicates.
3. **Pending buffer / no bubble.**
   - Stimulus: load A=0x04030201 (`last`=0); at cycle 2 load B=0x08070605 (`last`=1).
   - Required: 8 contiguous transfers 01..08; `out_done` only after 08.
4. **Overrun.**
   - Stimulus: `ready`=0; load A, B, C.
   - Required: `overrun`=1; the stream drains A then B only.
   - Follow-up: `clr` clears `overrun`, `busy` and `out_done`.
5. **`enable` gating.**
   - Stimulus: `enable`=0 for 3 cycles mid-batch with `ready`=1.
   - Required: no transfers during those cycles, outputs frozen. Resumes at the same lane.
6. **Async reset mid-batch.**
   - Stimulus: assert `reset`=0 after lane 1 of a batch.
   - Required: all outputs 0 immediately. After release, `dout_valid` stays 0 until the next load.
